// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Optional feature macro used by this slice: ADDER_OVERFLOW_EN.
package cla_pkg;

  localparam int GROUP_DEFAULT = 4;
  localparam int MAX_GROUP     = 8;

  // Result of one lookahead stage; only the low GROUP sum bits are meaningful.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [MAX_GROUP-1:0] sum;
  } stage_t;

  function automatic int num_groups(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Handshake and data bundle for pipelined_cla_adder.
// The overflow signal exists only when ADDER_OVERFLOW_EN is defined.
interface pipelined_cla_adder_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
`ifdef ADDER_OVERFLOW_EN
    , output overflow
`endif
  );

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
`ifdef ADDER_OVERFLOW_EN
    , input overflow
`endif
  );

endinterface

// File: rtl/pipelined_cla_adder_cla_group.sv
// Combinational GROUP-bit carry-lookahead group with group propagate/generate.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             cin_i,
  output logic [GROUP-1:0] sum_o,
  output logic             cout_o,
  output logic             p_o,
  output logic             g_o
);

  logic [GROUP-1:0] p_s;
  logic [GROUP-1:0] g_s;
  logic [GROUP:1]   gen_s;
  logic [GROUP:0]   prop_s;
  logic [GROUP:0]   c_s;
  logic             run_s;

  assign p_s = a_i ^ b_i;
  assign g_s = a_i & b_i;

  // Each carry is a flat sum of products: generate terms plus all-propagate times cin.
  always_comb begin
    gen_s     = '0;
    prop_s    = '0;
    c_s       = '0;
    run_s     = 1'b0;
    prop_s[0] = 1'b1;
    c_s[0]    = cin_i;
    for (int i = 0; i < GROUP; i++) begin
      prop_s[i+1] = prop_s[i] & p_s[i];
      for (int j = 0; j <= i; j++) begin
        run_s = g_s[j];
        for (int m = j + 1; m <= i; m++) begin
          run_s = run_s & p_s[m];
        end
        gen_s[i+1] = gen_s[i+1] | run_s;
      end
      c_s[i+1] = gen_s[i+1] | (prop_s[i+1] & cin_i);
    end
  end

  assign sum_o  = p_s ^ c_s[GROUP-1:0];
  assign cout_o = c_s[GROUP];
  assign p_o    = prop_s[GROUP];
  assign g_o    = gen_s[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one register stage per GROUP-bit group, valid/ready flow control.
// Define ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = GROUP_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int NG = num_groups(WIDTH, GROUP);

  logic             adv_s;
  logic [NG-1:0]    vld_q, vld_d;
  logic [NG-1:0]    cry_q, cry_d;
  logic [WIDTH-1:0] a_q [NG];
  logic [WIDTH-1:0] a_d [NG];
  logic [WIDTH-1:0] b_q [NG];
  logic [WIDTH-1:0] b_d [NG];
  logic [WIDTH-1:0] s_q [NG];
  logic [WIDTH-1:0] s_d [NG];
  logic [GROUP-1:0] gsum_s [NG];
  logic [NG-1:0]    gcout_s;
  logic [NG-1:0]    gp_s;
  logic [NG-1:0]    gg_s;
  stage_t           grp_s [NG];

  logic             out_valid_q, out_valid_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] sum_q, sum_d;
`ifdef ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Stage k operates on operand bits skewed by k registers and the carry from stage k-1.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic unused_grp_s;
    cla_group #(.GROUP(GROUP)) u_grp (
      .a_i   (a_q[g][g*GROUP +: GROUP]),
      .b_i   (b_q[g][g*GROUP +: GROUP]),
      .cin_i (cry_q[g]),
      .sum_o (gsum_s[g]),
      .cout_o(gcout_s[g]),
      .p_o   (gp_s[g]),
      .g_o   (gg_s[g])
    );
    assign grp_s[g]     = '{valid: vld_q[g], carry: gcout_s[g], sum: MAX_GROUP'(gsum_s[g])};
    assign unused_grp_s = ^{gp_s[g], gg_s[g], grp_s[g]};
  end

  logic unused_ops_s;
  assign unused_ops_s = ^{a_q[NG-1], b_q[NG-1]};

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv_s = ~out_valid_q | bus.out_ready;

  // Next-state for the skew/deskew shift chain and the output register.
  always_comb begin
    vld_d = '0;
    cry_d = '0;
    for (int k = 0; k < NG; k++) begin
      a_d[k] = '0;
      b_d[k] = '0;
      s_d[k] = '0;
    end
    vld_d[0] = bus.in_valid;
    cry_d[0] = bus.cin;
    a_d[0]   = bus.a;
    b_d[0]   = bus.b;
    for (int k = 1; k < NG; k++) begin
      vld_d[k] = grp_s[k-1].valid;
      cry_d[k] = grp_s[k-1].carry;
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      s_d[k]   = s_q[k-1];
      s_d[k][(k-1)*GROUP +: GROUP] = grp_s[k-1].sum[GROUP-1:0];
    end
    out_valid_d = grp_s[NG-1].valid;
    cout_d      = grp_s[NG-1].carry;
    sum_d       = s_q[NG-1];
    sum_d[(NG-1)*GROUP +: GROUP] = grp_s[NG-1].sum[GROUP-1:0];
`ifdef ADDER_OVERFLOW_EN
    // Carry into the MSB is recovered from its sum bit and operand bits.
    ovf_d = a_q[NG-1][WIDTH-1] ^ b_q[NG-1][WIDTH-1] ^ sum_d[WIDTH-1] ^ cout_d;
`endif
  end

  // Control and output registers: cleared on reset, frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else if (adv_s) begin
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
`ifdef ADDER_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end else begin
      vld_q       <= vld_q;
      out_valid_q <= out_valid_q;
      sum_q       <= sum_q;
      cout_q      <= cout_q;
`ifdef ADDER_OVERFLOW_EN
      ovf_q       <= ovf_q;
`endif
    end
  end

  // Intermediate data needs no reset; its valid bit gates its meaning.
  always_ff @(posedge clk) begin
    if (adv_s) begin
      cry_q <= cry_d;
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end else begin
      cry_q <= cry_q;
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef ADDER_OVERFLOW_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: randomized and directed adds against an arithmetic model.
module tb_pipelined_cla_adder;

  localparam int W = 16;
  localparam int G = 4;
  localparam int L = W / G;

  typedef struct {
    logic [W:0] res;
    logic       ovf;
    int         acc;
    bit         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_sum(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one op and wait (bounded) for acceptance; called at a falling edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input bit lat, input logic [W:0] er, input logic eo);
    int   waited;
    exp_t e;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.cin      = tc;
    #1;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (bus.in_ready) begin
      e.res = er;
      e.ovf = eo;
      e.acc = cyc + 1;
      e.lat = lat;
      sb.push_back(e);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic issue_rand(input bit lat);
    logic [W-1:0] ra, rb;
    logic         rc;
    ra = W'($urandom);
    rb = W'($urandom);
    rc = 1'($urandom);
    issue(ra, rb, rc, lat, ref_sum(ra, rb, rc), ref_ovf(ra, rb, rc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  // Monitor: pops and compares whenever a result transfers.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got sum %h cout %b, expected no result", bus.sum, bus.cout);
        end else begin
          e = sb.pop_front();
          chk("sum", 64'(bus.sum), 64'(e.res[W-1:0]));
          chk("cout", 64'(bus.cout), 64'(e.res[W]));
`ifdef ADDER_OVERFLOW_EN
          chk("overflow", 64'(bus.overflow), 64'(e.ovf));
`endif
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(L));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb, held;
    logic         rc;
    int           waited;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    held          = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_sum", 64'(bus.sum), 64'(0));
    chk("rst_cout", 64'(bus.cout), 64'(0));
`ifdef ADDER_OVERFLOW_EN
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    issue(16'h0002, 16'h0005, 1'b1, 1'b1, 17'h0_0008, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b1, 17'h1_0000, 1'b0);
    issue(16'hA00A, 16'hF00F, 1'b0, 1'b1, 17'h1_9019, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b1, 17'h0_8000, 1'b1);
    issue(16'h8000, 16'hFFFF, 1'b0, 1'b1, 17'h1_7FFF, 1'b1);
    issue(16'h0001, 16'h0001, 1'b0, 1'b1, 17'h0_0002, 1'b0);
    idle(2);

    for (int i = 0; i < 100; i++) issue_rand(1'b1);

    for (int i = 0; i < 10; i++) issue_rand(1'b0);
    ra = W'($urandom);
    rb = W'($urandom);
    rc = 1'($urandom);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = ra;
    bus.b         = rb;
    bus.cin       = rc;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
      chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
      if (i == 0) held = bus.sum;
      else chk("stall_sum_stable", 64'(bus.sum), 64'(held));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    issue(ra, rb, rc, 1'b0, ref_sum(ra, rb, rc), ref_ovf(ra, rb, rc));
    for (int i = 0; i < 10; i++) issue_rand(1'b0);
    idle(L + 4);
    chk("drained_before_reset", 64'(sb.size()), 64'(0));

    for (int i = 0; i < 3; i++) issue_rand(1'b1);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("midrst_sum", 64'(bus.sum), 64'(0));
    chk("midrst_cout", 64'(bus.cout), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(L + 6);

    for (int i = 0; i < 8; i++) issue_rand(1'b1);
    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      idle(1);
      waited++;
    end
    idle(2);
    chk("all_results_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
